// File: rtl/c2_ms_serial_converter.sv
// c2_ms_serial_converter
//
// Bit-serial two's complement to sign-magnitude converter. An operand is
// accepted in one cycle, then its bits are walked LSB first over N cycles
// using serial negation (copy up to and including the first 1, invert the
// rest), so no adder or full negator is needed. The result is held until the
// consumer takes it.
//
// Ports:
//   clock      in   system clock, rising-edge active
//   reset_     in   asynchronous active-low reset
//   x_c2       in   N-bit two's complement operand
//   in_valid   in   operand valid
//   in_ready   out  converter can accept an operand (IDLE only)
//   z_abs      out  N-bit unsigned magnitude |x_c2|
//   sgn        out  sign, 1 = negative
//   ow         out  magnitude needs N bits (x_c2 = -2^(N-1))
//   out_valid  out  result valid (DONE only)
//   out_ready  in   consumer accepts result

module c2_ms_serial_converter #(
    parameter int unsigned N = 4
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic [N-1:0] x_c2,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] z_abs,
    output logic         sgn,
    output logic         ow,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int unsigned CntW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(N - 1);
    // Most negative value: its magnitude does not fit N-bit sign-magnitude.
    localparam logic [N-1:0] MinNeg = {1'b1, {(N - 1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    word_q, word_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            seen_one_q, seen_one_d;
    logic [N-1:0]    z_abs_q, z_abs_d;
    logic            sgn_q, sgn_d;
    logic            ow_q, ow_d;

    logic            cur_bit;
    logic            mag_bit;
    logic            last_bit;

    assign cur_bit  = word_q[cnt_q];
    // Negative words invert every bit after the first 1 has been seen.
    assign mag_bit  = cur_bit ^ (sgn_q & seen_one_q);
    assign last_bit = (cnt_q == LastBit);

    // State register
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (last_bit) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // Back to IDLE only; accepting again needs one more cycle.
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle:  in_ready  = 1'b1;
            StShift: ;
            StDone:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state
    always_comb begin
        word_d     = word_q;
        cnt_d      = cnt_q;
        seen_one_d = seen_one_q;
        z_abs_d    = z_abs_q;
        sgn_d      = sgn_q;
        ow_d       = ow_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    word_d     = x_c2;
                    sgn_d      = x_c2[N-1];
                    cnt_d      = '0;
                    seen_one_d = 1'b0;
                    z_abs_d    = '0;
                    ow_d       = 1'b0;
                end
            end
            StShift: begin
                // Result fills from the MSB end, so after N shifts bit 0 of
                // the operand lands at bit 0 of the magnitude.
                z_abs_d    = {mag_bit, z_abs_q[N-1:1]};
                seen_one_d = seen_one_q | cur_bit;
                cnt_d      = cnt_q + CntW'(1);
                if (last_bit) begin
                    ow_d = (word_q == MinNeg);
                end
            end
            StDone: ;
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            word_q     <= '0;
            cnt_q      <= '0;
            seen_one_q <= 1'b0;
            z_abs_q    <= '0;
            sgn_q      <= 1'b0;
            ow_q       <= 1'b0;
        end else begin
            word_q     <= word_d;
            cnt_q      <= cnt_d;
            seen_one_q <= seen_one_d;
            z_abs_q    <= z_abs_d;
            sgn_q      <= sgn_d;
            ow_q       <= ow_d;
        end
    end

    assign z_abs = z_abs_q;
    assign sgn   = sgn_q;
    assign ow    = ow_q;

endmodule

// File: tb/tb_c2_ms_serial_converter.sv
module tb_c2_ms_serial_converter;

    typedef struct {
        logic [3:0] x;
        logic [3:0] z;
        logic       s;
        logic       o;
    } exp4_t;

    typedef struct {
        logic [7:0] x;
        logic [7:0] z;
        logic       s;
        logic       o;
    } exp8_t;

    logic clk;
    logic rst_n;

    logic [3:0] x4;
    logic       iv4, ir4, ov4, or4, s4, o4;
    logic [3:0] z4;

    logic [7:0] x8;
    logic       iv8, ir8, ov8, or8, s8, o8;
    logic [7:0] z8;

    int tests;
    int fails;
    int pops4;
    int pops8;
    int ow8_count;

    exp4_t q4[$];
    exp8_t q8[$];

    c2_ms_serial_converter #(.N(4)) u_dut4 (
        .clock    (clk),
        .reset_   (rst_n),
        .x_c2     (x4),
        .in_valid (iv4),
        .in_ready (ir4),
        .z_abs    (z4),
        .sgn      (s4),
        .ow       (o4),
        .out_valid(ov4),
        .out_ready(or4)
    );

    c2_ms_serial_converter #(.N(8)) u_dut8 (
        .clock    (clk),
        .reset_   (rst_n),
        .x_c2     (x8),
        .in_valid (iv8),
        .in_ready (ir8),
        .z_abs    (z8),
        .sgn      (s8),
        .ow       (o8),
        .out_valid(ov8),
        .out_ready(or8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // sign-magnitude back to two's complement, the companion converter's job
    function automatic logic [3:0] sm2c2(input logic [3:0] z, input logic s);
        logic [3:0] r;
        r = s ? (4'd0 - z) : z;
        return r;
    endfunction

    // Scoreboard monitors: a transfer happens on a rising edge with valid & ready.
    always @(posedge clk) begin
        if (rst_n && ov4 && or4) begin
            pops4++;
            tests++;
            if (q4.size() == 0) begin
                fails++;
                $display("FAIL n4_unexpected_output: got z=%b s=%b o=%b, expected none",
                         z4, s4, o4);
            end else begin
                exp4_t e;
                e = q4.pop_front();
                if (z4 !== e.z || s4 !== e.s || o4 !== e.o) begin
                    fails++;
                    $display("FAIL n4_result x=%b: got z=%b s=%b o=%b expected z=%b s=%b o=%b",
                             e.x, z4, s4, o4, e.z, e.s, e.o);
                end
                check("n4_round_trip", 32'(sm2c2(z4, s4)), 32'(e.x));
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && ov8 && or8) begin
            pops8++;
            tests++;
            if (o8 === 1'b1) ow8_count++;
            if (q8.size() == 0) begin
                fails++;
                $display("FAIL n8_unexpected_output: got z=%h s=%b o=%b, expected none",
                         z8, s8, o8);
            end else begin
                exp8_t e;
                e = q8.pop_front();
                if (z8 !== e.z || s8 !== e.s || o8 !== e.o) begin
                    fails++;
                    $display("FAIL n8_result x=%h: got z=%h s=%b o=%b expected z=%h s=%b o=%b",
                             e.x, z8, s8, o8, e.z, e.s, e.o);
                end
            end
        end
    end

    // Wait for in_ready, present one operand for one accept edge, log expectation.
    task automatic send4(input logic [3:0] x, input logic [3:0] z, input logic s, input logic o);
        int n;
        exp4_t e;
        n = 0;
        @(negedge clk);
        while (!ir4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("n4_accept_timeout", 32'(ir4), 32'd1);
        x4  = x;
        iv4 = 1'b1;
        e.x = x; e.z = z; e.s = s; e.o = o;
        q4.push_back(e);
        @(posedge clk);
        #1 iv4 = 1'b0;
    endtask

    task automatic wait_ov4(output int edges);
        edges = 0;
        while (!ov4 && edges < 50) begin
            @(posedge clk);
            #1 edges++;
        end
    endtask

    task automatic drain4();
        int n;
        n = 0;
        while (q4.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("n4_drain", 32'(q4.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp4_t vec[$];
        int k;
        logic [3:0] hz;
        logic       hs, ho;
        int p;

        tests = 0; fails = 0; pops4 = 0; pops8 = 0; ow8_count = 0;
        rst_n = 1'b0;
        x4 = '0; iv4 = 1'b0; or4 = 1'b1;
        x8 = '0; iv8 = 1'b0; or8 = 1'b1;

        // Reset state
        #12;
        check("rst_in_ready4", 32'(ir4), 32'd1);
        check("rst_out_valid4", 32'(ov4), 32'd0);
        check("rst_outs4", 32'({z4, s4, o4}), 32'd0);
        check("rst_in_ready8", 32'(ir8), 32'd1);
        check("rst_outs8", 32'({ov8, z8, s8, o8}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Latency and handshake: 0101
        send4(4'b0101, 4'b0101, 1'b0, 1'b0);
        check("in_ready_after_accept", 32'(ir4), 32'd0);
        wait_ov4(k);
        // k counts edges after the accept edge; accept edge itself makes N+1
        check("latency_edges", 32'(k + 1), 32'd5);
        check("in_ready_while_valid", 32'(ir4), 32'd0);
        @(posedge clk);
        #1;
        check("out_valid_drop", 32'(ov4), 32'd0);
        check("in_ready_return", 32'(ir4), 32'd1);

        // Directed sweep, hand-computed results
        vec.push_back('{4'b1011, 4'b0101, 1'b1, 1'b0});
        vec.push_back('{4'b1111, 4'b0001, 1'b1, 1'b0});
        vec.push_back('{4'b1100, 4'b0100, 1'b1, 1'b0});
        vec.push_back('{4'b0000, 4'b0000, 1'b0, 1'b0});
        vec.push_back('{4'b1000, 4'b1000, 1'b1, 1'b1});
        vec.push_back('{4'b0111, 4'b0111, 1'b0, 1'b0});
        vec.push_back('{4'b0001, 4'b0001, 1'b0, 1'b0});
        foreach (vec[i]) send4(vec[i].x, vec[i].z, vec[i].s, vec[i].o);
        drain4();

        // Backpressure
        or4 = 1'b0;
        send4(4'b1011, 4'b0101, 1'b1, 1'b0);
        wait_ov4(k);
        check("bp_valid", 32'(ov4), 32'd1);
        hz = z4; hs = s4; ho = o4;
        p = pops4;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            x4 = 4'b0110; iv4 = 1'b1;
            @(posedge clk);
            #1;
            check("bp_hold_valid", 32'(ov4), 32'd1);
            check("bp_in_ready", 32'(ir4), 32'd0);
            check("bp_stable", 32'({z4, s4, o4}), 32'({hz, hs, ho}));
        end
        @(negedge clk);
        or4 = 1'b1;
        @(posedge clk);
        #1;
        check("bp_one_transfer", 32'(pops4 - p), 32'd1);
        check("bp_valid_drop", 32'(ov4), 32'd0);
        check("bp_ready_up", 32'(ir4), 32'd1);
        q4.push_back('{4'b0110, 4'b0110, 1'b0, 1'b0});
        @(posedge clk);
        #1 iv4 = 1'b0;
        check("bp_new_accepted", 32'(ir4), 32'd0);
        drain4();
        check("bp_total_transfers", 32'(pops4 - p), 32'd2);

        // Reset mid-SHIFT
        send4(4'b1101, 4'b0011, 1'b1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(ir4), 32'd1);
        check("midrst_out_valid", 32'(ov4), 32'd0);
        check("midrst_outs", 32'({z4, s4, o4}), 32'd0);
        void'(q4.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        send4(4'b1001, 4'b0111, 1'b1, 1'b0);
        drain4();

        // N=8 exhaustive, back-to-back, reference model
        for (int i = 0; i < 256; i++) begin
            exp8_t e;
            int n;
            n = 0;
            @(negedge clk);
            while (!ir8 && n < 50) begin
                iv8 = 1'b0;
                @(negedge clk);
                n++;
            end
            if (!ir8) check("n8_accept_timeout", 32'(ir8), 32'd1);
            x8  = 8'(i);
            iv8 = 1'b1;
            e.x = 8'(i);
            e.s = e.x[7];
            e.z = e.x[7] ? 8'(256 - i) : e.x;
            e.o = (i == 128);
            q8.push_back(e);
            @(posedge clk);
            #1;
        end
        iv8 = 1'b0;
        k = 0;
        while (q8.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        check("n8_drain", 32'(q8.size()), 32'd0);
        check("n8_transfers", 32'(pops8), 32'd256);
        check("n8_ow_count", 32'(ow8_count), 32'd1);
        check("n4_no_extra", 32'(q4.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
